spi_xfer_seq: RTL and testbench

SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

---
 rtl/spi_xfer_seq.sv | 215 +++++++++++++++++++++
 tb/tb_spi_xfer_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: chip-select / byte sequencer in front of an SPI byte engine.
// Bytes come from a tx FIFO (0x00 when it is empty) and are shifted one at a
// time through the engine; each received byte goes into an rx FIFO (FWFT).
// Optional feature macro: SPI_XFER_SEQ_OVF_FLAG_EN (sticky rx overflow flag).
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | cs_n high, waiting for go with a non-zero len
// CS_SETUP   | cs_n low, CS_DELAY cycles before the first byte
// LOAD       | waiting for the engine to be free, then issue spi_start
// WAIT_BYTE  | waiting for spi_new_data from the engine
// CS_HOLD    | cs_n still low, CS_DELAY cycles after the last byte
module spi_xfer_seq #(
   parameter int CS_DELAY   = 2,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_wr,
   input  logic [7:0] tx_data,
   output logic       tx_full,
   input  logic       rx_rd,
   output logic [7:0] rx_data,
   output logic       rx_empty,
   input  logic       go,
   input  logic [7:0] len,
   output logic       busy,
   output logic       done,
   output logic       rx_ovf,
   output logic       cs_n,
   output logic       spi_start,
   output logic [7:0] spi_data_in,
   input  logic       spi_busy,
   input  logic       spi_new_data,
   input  logic [7:0] spi_data_out
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [3:0] DLY_LOAD = 4'(CS_DELAY - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_CS_SETUP  = 3'd1;
   localparam logic [2:0] S_LOAD      = 3'd2;
   localparam logic [2:0] S_WAIT_BYTE = 3'd3;
   localparam logic [2:0] S_CS_HOLD   = 3'd4;

   logic [2:0]    r_state;
   logic [3:0]    r_timer;
   logic [7:0]    r_remaining;
   logic          r_cs_n;
   logic          r_done;

   logic [7:0]    r_tx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_tx_rd_ptr;
   logic [AW-1:0] r_tx_wr_ptr;
   logic [AW:0]   r_tx_count;

   logic [7:0]    r_rx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_rx_rd_ptr;
   logic [AW-1:0] r_rx_wr_ptr;
   logic [AW:0]   r_rx_count;

   logic w_go_accept;
   logic w_load_fire;
   logic w_tx_empty;
   logic w_tx_push;
   logic w_tx_pop;
   logic w_rx_full;
   logic w_rx_in;
   logic w_rx_push;
   logic w_rx_pop;

   assign w_go_accept = (r_state == S_IDLE) && go && (len != 8'd0);
   assign w_load_fire = (r_state == S_LOAD) && !spi_busy;

   assign w_tx_empty = (r_tx_count == '0);
   assign tx_full    = (r_tx_count == DEPTH_C);
   assign w_tx_push  = tx_wr && !tx_full;
   assign w_tx_pop   = w_load_fire && !w_tx_empty;

   assign w_rx_full  = (r_rx_count == DEPTH_C);
   assign rx_empty   = (r_rx_count == '0);
   assign w_rx_in    = (r_state == S_WAIT_BYTE) && spi_new_data;
   assign w_rx_push  = w_rx_in && !w_rx_full;
   assign w_rx_pop   = rx_rd && !rx_empty;
   assign rx_data    = r_rx_mem[r_rx_rd_ptr];

   // spi_start is combinational so the engine sees the byte in the very cycle
   // LOAD finds it free; the data bus idles at 0x00 outside that pulse.
   assign spi_start   = w_load_fire;
   assign spi_data_in = (w_load_fire && !w_tx_empty) ? r_tx_mem[r_tx_rd_ptr] : 8'h00;

   assign busy = (r_state != S_IDLE);
   assign cs_n = r_cs_n;
   assign done = r_done;

   // tx FIFO storage
   always_ff @(posedge clk) begin
      if (w_tx_push)
         r_tx_mem[r_tx_wr_ptr] <= tx_data;
   end

   // tx FIFO pointers and occupancy; push and pop in one cycle cancel in the count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_rd_ptr <= '0;
         r_tx_wr_ptr <= '0;
         r_tx_count  <= '0;
      end else begin
         if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
         if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_count <= r_tx_count + 1'b1;
            2'b01:   r_tx_count <= r_tx_count - 1'b1;
            default: r_tx_count <= r_tx_count;
         endcase
      end
   end

   // rx FIFO storage; a byte arriving while full is simply not written
   always_ff @(posedge clk) begin
      if (w_rx_push)
         r_rx_mem[r_rx_wr_ptr] <= spi_data_out;
   end

   // rx FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_rd_ptr <= '0;
         r_rx_wr_ptr <= '0;
         r_rx_count  <= '0;
      end else begin
         if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
         if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_count <= r_rx_count + 1'b1;
            2'b01:   r_rx_count <= r_rx_count - 1'b1;
            default: r_rx_count <= r_rx_count;
         endcase
      end
   end

   // Transfer sequencer; cs_n and done are registered so they change together
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_remaining <= '0;
         r_cs_n      <= 1'b1;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_go_accept) begin
                  r_remaining <= len;
                  r_timer     <= DLY_LOAD;
                  r_cs_n      <= 1'b0;
                  r_state     <= S_CS_SETUP;
               end
            end
            S_CS_SETUP: begin
               if (r_timer == 4'd0) r_state <= S_LOAD;
               else                 r_timer <= r_timer - 1'b1;
            end
            S_LOAD: begin
               if (!spi_busy) r_state <= S_WAIT_BYTE;
            end
            S_WAIT_BYTE: begin
               // completion is the new_data pulse alone; spi_busy is not trusted here
               if (spi_new_data) begin
                  r_remaining <= r_remaining - 1'b1;
                  if (r_remaining == 8'd1) begin
                     r_timer <= DLY_LOAD;
                     r_state <= S_CS_HOLD;
                  end else begin
                     r_state <= S_LOAD;
                  end
               end
            end
            S_CS_HOLD: begin
               if (r_timer == 4'd0) begin
                  r_cs_n  <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            default: begin
               r_cs_n  <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SPI_XFER_SEQ_OVF_FLAG_EN
   logic w_rx_drop;
   logic r_rx_ovf;

   assign w_rx_drop = w_rx_in && w_rx_full;
   assign rx_ovf    = r_rx_ovf;

   // Sticky overflow: set by any dropped rx byte, cleared when a new transfer starts
   always_ff @(posedge clk) begin
      if (rst || w_go_accept) r_rx_ovf <= 1'b0;
      else if (w_rx_drop)     r_rx_ovf <= 1'b1;
   end
`else
   assign rx_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Bench for spi_xfer_seq: engine model echoes the inverted byte, a transfer-level
// reference predicts the bytes sent and received, and a negedge monitor checks them.
module tb_spi_xfer_seq;

   localparam int CS_DELAY = 2;
   localparam int DEPTH    = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_wr;
   logic [7:0] tx_data;
   logic       tx_full;
   logic       rx_rd;
   logic [7:0] rx_data;
   logic       rx_empty;
   logic       go;
   logic [7:0] len;
   logic       busy;
   logic       done;
   logic       rx_ovf;
   logic       cs_n;
   logic       spi_start;
   logic [7:0] spi_data_in;
   logic       spi_busy;
   logic       spi_new_data;
   logic [7:0] spi_data_out;

   spi_xfer_seq #(.CS_DELAY(CS_DELAY), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
      .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .go(go), .len(len),
      .busy(busy), .done(done), .rx_ovf(rx_ovf), .cs_n(cs_n), .spi_start(spi_start),
      .spi_data_in(spi_data_in), .spi_busy(spi_busy), .spi_new_data(spi_new_data),
      .spi_data_out(spi_data_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] txm[$];      // reference tx FIFO contents
   logic [7:0] exp_tx[$];   // bytes expected on spi_data_in, in order
   logic [7:0] exp_rx[$];   // bytes expected out of the rx FIFO, in order
   int         exp_done = 0;
   logic       exp_drop = 1'b0;
   logic       abort = 1'b0;
   logic       stray_req = 1'b0;

   int   cyc = 0;
   int   t_fall = 0;
   int   t_nd = 0;
   logic first_pend = 1'b0;
   logic prev_cs = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   task automatic fail_evt(input string nm);
      checks++;
      errors++;
      $display("FAIL %s actual=event required=none", nm);
   endtask

   // Reference: a transfer of l bytes takes tx bytes in order (0x00 once empty),
   // the engine returns each inverted, and the rx FIFO keeps only what fits.
   function automatic void predict(input int l);
      logic [7:0] b;
      exp_drop = 1'b0;
      for (int i = 0; i < l; i++) begin
         b = (txm.size() > 0) ? txm.pop_front() : 8'h00;
         exp_tx.push_back(b);
         if (exp_rx.size() < DEPTH) exp_rx.push_back(~b);
         else                       exp_drop = 1'b1;
      end
      if (l != 0) exp_done++;
   endfunction

   // Byte engine model: takes a start, stays busy a random time, returns ~byte
   initial begin
      logic [7:0] b;
      int lat;
      spi_busy = 1'b0; spi_new_data = 1'b0; spi_data_out = 8'h00;
      forever begin
         @(negedge clk);
         if (spi_start) begin
            b = spi_data_in;
            @(posedge clk); #1 spi_busy = 1'b1;
            lat = $urandom_range(0, 3);
            repeat (lat) @(posedge clk);
            if (lat != 0) #1;
            spi_new_data = 1'b1; spi_data_out = ~b; spi_busy = 1'b0;
            @(posedge clk); #1 spi_new_data = 1'b0;
         end else if (stray_req) begin
            stray_req = 1'b0;
            @(posedge clk); #1 spi_new_data = 1'b1; spi_data_out = 8'h99;
            @(posedge clk); #1 spi_new_data = 1'b0;
         end
      end
   end

   // Monitor: compares every DUT-presented event against the expectation queues
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (prev_cs && !cs_n) begin t_fall = cyc; first_pend = 1'b1; end
         if (spi_start) begin
            chk("cs_low_at_start", 32'(cs_n), 32'd0);
            if (first_pend) begin
               chk("cs_setup_cycles", 32'(cyc - t_fall), 32'(CS_DELAY));
               first_pend = 1'b0;
            end
            if (exp_tx.size() == 0) fail_evt("unexpected_spi_start");
            else begin
               e = exp_tx.pop_front();
               chk("spi_data_in", 32'(spi_data_in), 32'(e));
            end
         end
         if (spi_new_data && !cs_n) t_nd = cyc;
         if (!prev_cs && cs_n && !abort) begin
            chk("done_at_cs_rise", 32'(done), 32'd1);
            chk("cs_hold_cycles", 32'(cyc - t_nd), 32'(CS_DELAY + 1));
         end
         if (done) begin
            chk("busy_at_done", 32'(busy), 32'd0);
            if (exp_done == 0) fail_evt("unexpected_done");
            else begin checks++; exp_done--; end
         end
         if (rx_rd && !rx_empty) begin
            if (exp_rx.size() == 0) fail_evt("unexpected_rx_byte");
            else begin
               e = exp_rx.pop_front();
               chk("rx_data", 32'(rx_data), 32'(e));
            end
         end
         prev_cs = cs_n;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic push_tx(input logic [7:0] d);
      tx_wr = 1'b1; tx_data = d;
      if (txm.size() < DEPTH) txm.push_back(d);
      @(posedge clk); #1 tx_wr = 1'b0;
   endtask

   task automatic pulse_go(input logic [7:0] l);
      go = 1'b1; len = l;
      @(posedge clk); #1 go = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((exp_done != 0 || busy) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("xfer_timeout", 32'(n < 3000), 32'd1);
   endtask

   task automatic check_ovf();
`ifdef SPI_XFER_SEQ_OVF_FLAG_EN
      chk("rx_ovf", 32'(rx_ovf), 32'(exp_drop));
`else
      chk("rx_ovf", 32'(rx_ovf), 32'd0);
`endif
   endtask

   task automatic drain_rx();
      int n = 0;
      while (!rx_empty && n < DEPTH + 4) begin
         rx_rd = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      rx_rd = 1'b0;
      chk("rx_missing_bytes", 32'(exp_rx.size()), 32'd0);
   endtask

   initial begin
      int n;
      int l;
      int np;
      rst = 1'b1; tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0; go = 1'b0; len = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rx_empty", 32'(rx_empty), 32'd1);
      chk("rst_tx_full", 32'(tx_full), 32'd0);
      chk("rst_spi_start", 32'(spi_start), 32'd0);
      chk("rst_spi_data_in", 32'(spi_data_in), 32'd0);
      chk("rst_rx_ovf", 32'(rx_ovf), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // two-byte echo
      push_tx(8'hA5); push_tx(8'h3C);
      predict(2); pulse_go(8'd2);
      wait_done(); check_ovf(); drain_rx();

      // empty tx FIFO: zeros go out
      predict(3); pulse_go(8'd3);
      wait_done(); check_ovf(); drain_rx();

      // overflow: 16 kept, 4 dropped
      for (int i = 0; i < DEPTH; i++) push_tx(8'($urandom));
      chk("tx_full_at_depth", 32'(tx_full), 32'd1);
      predict(20); pulse_go(8'd20);
      wait_done();
      chk("rx_full_no_read", 32'(rx_empty), 32'd0);
      check_ovf(); drain_rx();

      // push coinciding with the pop of the last tx entry
      push_tx(8'h77);
      txm.delete();
      exp_tx.push_back(8'h77); exp_tx.push_back(8'h11); exp_tx.push_back(8'h00);
      exp_rx.push_back(8'h88); exp_rx.push_back(8'hEE); exp_rx.push_back(8'hFF);
      exp_done++; exp_drop = 1'b0;
      pulse_go(8'd3);
      n = 0;
      do begin @(negedge clk); n++; end while (!spi_start && n < 100);
      chk("first_start_seen", 32'(spi_start), 32'd1);
      tx_wr = 1'b1; tx_data = 8'h11;
      @(negedge clk); tx_wr = 1'b0;
      @(posedge clk); #1;
      wait_done(); check_ovf(); drain_rx();

      // len 0 is a no-op
      pulse_go(8'd0);
      @(negedge clk);
      chk("len0_busy", 32'(busy), 32'd0);
      chk("len0_cs_n", 32'(cs_n), 32'd1);
      @(posedge clk); #1;

      // go while busy does not change the byte count
      predict(3); pulse_go(8'd3);
      repeat (3) @(posedge clk); #1;
      pulse_go(8'd7);
      wait_done(); drain_rx();

      // reset during the second WAIT_BYTE of a 4-byte transfer
      for (int i = 0; i < 4; i++) push_tx(8'($urandom));
      predict(4); pulse_go(8'd4);
      n = 0; np = 0;
      while (np < 2 && n < 200) begin
         @(negedge clk); n++;
         if (spi_start) np++;
      end
      chk("second_start_seen", 32'(np), 32'd2);
      @(posedge clk); #1;
      abort = 1'b1; rst = 1'b1;
      txm.delete(); exp_tx.delete(); exp_rx.delete(); exp_done = 0; exp_drop = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_cs_n", 32'(cs_n), 32'd1);
      chk("abort_rx_empty", 32'(rx_empty), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      @(posedge clk); #1 stray_req = 1'b1;
      repeat (12) @(posedge clk); #1;
      chk("stray_rx_empty", 32'(rx_empty), 32'd1);
      chk("stray_cs_n", 32'(cs_n), 32'd1);
      abort = 1'b0;

      // randomized transfers
      for (int it = 0; it < 15; it++) begin
         np = $urandom_range(0, DEPTH + 2);
         for (int i = 0; i < np; i++) push_tx(8'($urandom));
         l = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
         predict(l); pulse_go(8'(l));
         if (l == 0) begin
            @(negedge clk);
            chk("rand_len0_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
         end
         wait_done(); check_ovf(); drain_rx();
      end

      repeat (5) @(posedge clk); #1;
      chk("leftover_tx_expect", 32'(exp_tx.size()), 32'd0);
      chk("leftover_done_expect", 32'(exp_done), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
